// File: rtl/cache_fill_if.sv
// Handshake bundle between the fill controller, the cache arrays and memory.
// master: cache/memory side; slave: the fill controller.
interface cache_fill_if #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    logic                       miss_detected;
    logic [ADDR_W-1:0]          miss_address;
    logic                       memory_data_valid;
    logic                       mem_req;
    logic [ADDR_W-1:0]          memory_address;
    logic [ADDR_W-1:0]          cache_address;
    logic                       write_data_array;
    logic [WORDS_PER_BLOCK-1:0] wrd_en;
    logic                       write_tag_array;
    logic                       fsm_busy;
    logic                       stall;
    logic                       crit_word_valid;

    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  mem_req, memory_address, cache_address,
        input  write_data_array, wrd_en, write_tag_array,
        input  fsm_busy, stall, crit_word_valid
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output mem_req, memory_address, cache_address,
        output write_data_array, wrd_en, write_tag_array,
        output fsm_busy, stall, crit_word_valid
    );
endinterface

// File: rtl/cache_block_fill_ctrl.sv
// Parametrised cache-miss block fill controller (IDLE -> FILL -> TAG).
// Define CACHE_CRIT_WORD_FIRST_EN for critical-word-first wrapping fill.
module cache_block_fill_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int WORD_BYTES      = 2,
    parameter int WORDS_PER_BLOCK = 8
) (
    input logic         clk,
    input logic         rst,
    cache_fill_if.slave bus
);
    localparam int WI_W  = $clog2(WORDS_PER_BLOCK);
    localparam int BO_W  = $clog2(WORD_BYTES);
    localparam int OFF_W = WI_W + BO_W;
    localparam int BLK_W = ADDR_W - OFF_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_TAG  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [WI_W-1:0]  start_q, start_d;
    logic [WI_W:0]    iss_cnt_q, iss_cnt_d;
    logic [WI_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [WI_W-1:0]  iss_idx;
    logic [WI_W-1:0]  ret_idx;
    logic             unused_addr;

    // Index arithmetic wraps naturally at WI_W bits
    assign iss_idx     = start_q + iss_cnt_q[WI_W-1:0];
    assign ret_idx     = start_q + ret_cnt_q;
    assign unused_addr = ^bus.miss_address;

    assign bus.fsm_busy = (state_q != S_IDLE);
    assign bus.stall    = bus.fsm_busy |
                          ((state_q == S_IDLE) & bus.miss_detected);

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        start_d   = start_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        bus.mem_req          = 1'b0;
        bus.memory_address   = '0;
        bus.cache_address    = '0;
        bus.write_data_array = 1'b0;
        bus.wrd_en           = '0;
        bus.write_tag_array  = 1'b0;
        bus.crit_word_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_detected) begin
                    blk_d = bus.miss_address[ADDR_W-1:OFF_W];
`ifdef CACHE_CRIT_WORD_FIRST_EN
                    start_d = bus.miss_address[OFF_W-1:BO_W];
`else
                    start_d = '0;
`endif
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                // MSB of the issue count marks all requests sent
                if (!iss_cnt_q[WI_W]) begin
                    bus.mem_req        = 1'b1;
                    bus.memory_address =
                        ADDR_W'({blk_q, iss_idx}) << BO_W;
                    iss_cnt_d = iss_cnt_q + 1'b1;
                end
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.cache_address    =
                        ADDR_W'({blk_q, ret_idx}) << BO_W;
                    bus.wrd_en = WORDS_PER_BLOCK'(1) << ret_idx;
`ifdef CACHE_CRIT_WORD_FIRST_EN
                    bus.crit_word_valid = (ret_cnt_q == '0);
`endif
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == WI_W'(WORDS_PER_BLOCK - 1))
                        state_d = S_TAG;
                end
            end
            S_TAG: begin
                bus.write_tag_array = 1'b1;
                state_d             = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            start_q   <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            start_q   <= start_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end
endmodule

// File: tb/tb_cache_block_fill_ctrl.sv
// Scoreboard bench for cache_block_fill_ctrl (8x2B and 4x4B instances).
// Expected requests/writes are queued at miss time and popped on output.
module tb_cache_block_fill_ctrl;
`ifdef CACHE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) f8 ();
    cache_fill_if #(.ADDR_W(16), .WORDS_PER_BLOCK(4)) f4 ();

    cache_block_fill_ctrl #(
        .ADDR_W(16), .WORD_BYTES(2), .WORDS_PER_BLOCK(8)
    ) dut8 (.clk(clk), .rst(rst), .bus(f8.slave));

    cache_block_fill_ctrl #(
        .ADDR_W(16), .WORD_BYTES(4), .WORDS_PER_BLOCK(4)
    ) dut4 (.clk(clk), .rst(rst), .bus(f4.slave));

    int checks = 0;
    int errors = 0;

    logic [15:0] req_q[$];
    logic [24:0] wr_q[$];
    int tag_exp = 0, wr_cnt = 0, tag_n = 0, busy_cnt = 0;
    int first_wr_cyc = 0, tag_cyc = 0, acc_cyc = 0, cyc = 0;
    int pend = 0, gap = 0, stray_n = 0;
    bit gap_mode = 1'b0;
    bit prev_tag = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic [15:0] a);
        logic [2:0] st;
        logic [2:0] idx;
        st = CWF ? a[3:1] : 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = st + 3'(i);
            req_q.push_back({a[15:4], idx, 1'b0});
            wr_q.push_back({((i == 0) && CWF), a[15:4], idx, 1'b0,
                            8'(8'd1 << idx)});
        end
        tag_exp++;
    endtask

    task automatic issue(input logic [15:0] a);
        f8.miss_address  = a;
        f8.miss_detected = 1'b1;
        push_fill(a);
        acc_cyc = cyc;
        #1;
        check("stall_on_accept", 32'(f8.stall), 32'd1);
        tick();
        f8.miss_detected = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tag_exp > 0 || f8.fsm_busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("timeout_fill", 32'(tag_exp), 32'd0);
        check("req_left", 32'(req_q.size()), 32'd0);
        check("wr_left", 32'(wr_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            f8.memory_data_valid = 1'b0;
            gap = 0;
        end else if (stray_n > 0) begin
            stray_n--;
            f8.memory_data_valid = 1'b1;
        end else if (gap > 0) begin
            gap--;
            f8.memory_data_valid = 1'b0;
        end else if (pend > 0) begin
            pend--;
            f8.memory_data_valid = 1'b1;
            gap = gap_mode ? int'($urandom_range(3, 0)) : 0;
        end else begin
            f8.memory_data_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            wr_cnt = 0;
            prev_tag = 1'b0;
            check("rst_out8", 32'(|{f8.mem_req, f8.write_data_array,
                  f8.write_tag_array, f8.fsm_busy, f8.stall,
                  f8.crit_word_valid, f8.memory_address,
                  f8.cache_address, f8.wrd_en}), 32'd0);
            check("rst_out4", 32'(|{f4.mem_req, f4.write_data_array,
                  f4.write_tag_array, f4.fsm_busy, f4.stall,
                  f4.crit_word_valid, f4.memory_address,
                  f4.cache_address, f4.wrd_en}), 32'd0);
        end else begin
            if (f8.fsm_busy) busy_cnt++;
            if (f8.mem_req) begin
                pend++;
                if (req_q.size() == 0)
                    check("req_extra", 32'(f8.mem_req), 32'd0);
                else
                    check("req_addr", 32'(f8.memory_address),
                          32'(req_q.pop_front()));
            end else begin
                check("req_idle_addr", 32'(f8.memory_address), 32'd0);
            end
            if (f8.write_data_array) begin
                wr_cnt++;
                if (wr_cnt == 1) first_wr_cyc = cyc;
                if (wr_q.size() == 0)
                    check("wr_extra", 32'(f8.write_data_array), 32'd0);
                else
                    check("wr", 32'({f8.crit_word_valid, f8.cache_address,
                          f8.wrd_en}), 32'(wr_q.pop_front()));
            end else begin
                check("wr_idle", 32'({f8.crit_word_valid,
                      f8.cache_address, f8.wrd_en}), 32'd0);
            end
            if (f8.write_tag_array) begin
                check("tag_after_writes", 32'(wr_cnt), 32'd8);
                wr_cnt = 0;
                tag_n++;
                tag_cyc = cyc;
                if (tag_exp == 0)
                    check("tag_extra", 32'(f8.write_tag_array), 32'd0);
                else
                    tag_exp--;
            end
            if (prev_tag && !f8.miss_detected)
                check("stall_fall", 32'(f8.stall), 32'd0);
            prev_tag = f8.write_tag_array;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] req4[$];
        logic [19:0] wr4[$];
        logic [1:0]  st4;
        logic [1:0]  idx4;
        logic        r4;
        int          t0, n, tag4, wr4_cnt;

        f8.miss_detected = 1'b0;
        f8.miss_address  = '0;
        f8.memory_data_valid = 1'b0;
        f4.miss_detected = 1'b0;
        f4.miss_address  = '0;
        f4.memory_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Ideal memory fill with latency checks
        busy_cnt = 0;
        issue(16'h1236);
        wait_idle();
        check("lat_first_wr", 32'(first_wr_cyc - acc_cyc), 32'd2);
        check("lat_tag", 32'(tag_cyc - acc_cyc), 32'd10);
        check("busy_cycles", 32'(busy_cnt), 32'd10);

        issue(16'h123A);
        wait_idle();

        // Returns while idle must be ignored
        stray_n = 2;
        repeat (4) tick();
        check("stray_busy", 32'(f8.fsm_busy), 32'd0);

        // Random gaps between returns
        gap_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(16'($urandom));
            wait_idle();
        end
        gap_mode = 1'b0;

        // Second miss held high across a fill
        f8.miss_address  = 16'h1236;
        f8.miss_detected = 1'b1;
        push_fill(16'h1236);
        tick();
        f8.miss_address = 16'h4000;
        push_fill(16'h4000);
        t0 = tag_n;
        n = 0;
        while (tag_n == t0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("timeout_tag", 32'(tag_n), 32'(t0 + 1));
        check("idle_gap_busy", 32'(f8.fsm_busy), 32'd0);
        tick();
        f8.miss_detected = 1'b0;
        wait_idle();

        // Reset in the middle of a fill
        issue(16'h1236);
        n = 0;
        while (wr_cnt < 3 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        req_q.delete();
        wr_q.delete();
        tag_exp = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        issue(16'h2000);
        wait_idle();

        // 4-word, 4-byte instance
        st4 = CWF ? 2'd2 : 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx4 = st4 + 2'(i);
            req4.push_back({12'h010, idx4, 2'b00});
            wr4.push_back({12'h010, idx4, 2'b00, 4'(4'd1 << idx4)});
        end
        tag4 = 0;
        wr4_cnt = 0;
        f4.miss_address  = 16'h0108;
        f4.miss_detected = 1'b1;
        tick();
        f4.miss_detected = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (f4.mem_req) begin
                if (req4.size() == 0)
                    check("req4_extra", 32'(f4.mem_req), 32'd0);
                else
                    check("req4_addr", 32'(f4.memory_address),
                          32'(req4.pop_front()));
            end
            if (f4.write_data_array) begin
                wr4_cnt++;
                if (wr4.size() == 0)
                    check("wr4_extra", 32'(f4.write_data_array), 32'd0);
                else
                    check("wr4", 32'({f4.cache_address, f4.wrd_en}),
                          32'(wr4.pop_front()));
            end
            if (f4.write_tag_array) begin
                tag4++;
                check("tag4_after_writes", 32'(wr4_cnt), 32'd4);
            end
            r4 = f4.mem_req;
            @(posedge clk);
            #1;
            f4.memory_data_valid = r4;
        end
        check("tag4_count", 32'(tag4), 32'd1);
        check("req4_left", 32'(req4.size()), 32'd0);
        check("wr4_left", 32'(wr4.size()), 32'd0);
        check("busy4_end", 32'(f4.fsm_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
